// File: rtl/dw_ram_rw_arb.sv
// dw_ram_rw_arb: two-client round-robin arbiter and access sequencer for a single-port RAM.
// Strobes are registered so the address and data are stable around the wr_n rising edge.
module dw_ram_rw_arb #(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int addr_width = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [addr_width-1:0] i_addr0,
    input  logic [addr_width-1:0] i_addr1,
    input  logic [data_width-1:0] i_wdata0,
    input  logic [data_width-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_done0,
    output logic                  o_done1,
    output logic [data_width-1:0] o_rdata,
    output logic                  o_ram_rst_n,
    output logic                  o_ram_cs_n,
    output logic                  o_ram_wr_n,
    output logic [addr_width-1:0] o_ram_addr,
    output logic [data_width-1:0] o_ram_data_in,
    input  logic [data_width-1:0] i_ram_data_out
);
    typedef enum logic [1:0] {IDLE, READ, WR_SETUP, WR_HOLD} state_t;

    state_t                r_state, w_next;
    logic                  r_last, r_who, r_pend, r_done0, r_done1;
    logic                  r_ram_rst_n, r_ram_cs_n, r_ram_wr_n;
    logic [addr_width-1:0] r_ram_addr;
    logic [data_width-1:0] r_ram_data_in, r_rdata;
    logic                  w_pick1, w_grant, w_we, w_fin;
    logic [addr_width-1:0] w_addr;
    logic [data_width-1:0] w_wdata;

    always_comb begin
        w_pick1 = i_req1 & (~i_req0 | ~r_last);
        w_grant = (r_state == IDLE) & (i_req0 | i_req1);
        w_we    = w_pick1 ? i_we1 : i_we0;
        w_addr  = w_pick1 ? i_addr1 : i_addr0;
        w_wdata = w_pick1 ? i_wdata1 : i_wdata0;
        w_fin   = (r_state == READ) | (r_state == WR_HOLD);
        o_gnt0  = w_grant & ~w_pick1;
        o_gnt1  = w_grant & w_pick1;
        w_next  = r_state;
        case (r_state)
            IDLE:     w_next = w_grant ? (w_we ? WR_SETUP : READ) : IDLE;
            WR_SETUP: w_next = WR_HOLD;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    // Strobes are loaded from the next state so each one is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last        <= 1'b1;
            r_who         <= 1'b0;
            r_pend        <= 1'b1;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_rdata       <= '0;
            r_ram_rst_n   <= 1'b0;
            r_ram_cs_n    <= 1'b1;
            r_ram_wr_n    <= 1'b1;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
        end else begin
            r_pend      <= 1'b0;
            r_ram_rst_n <= ~r_pend;
            r_done0     <= w_fin & ~r_who;
            r_done1     <= w_fin & r_who;
            r_ram_cs_n  <= (w_next == IDLE);
            r_ram_wr_n  <= (w_next != WR_SETUP);
            if (r_state == READ) r_rdata <= i_ram_data_out;
            if (w_grant) begin
                r_last     <= w_pick1;
                r_who      <= w_pick1;
                r_ram_addr <= w_addr;
                if (w_we) r_ram_data_in <= w_wdata;
            end
        end
    end

    assign o_done0       = r_done0;
    assign o_done1       = r_done1;
    assign o_rdata       = r_rdata;
    assign o_ram_rst_n   = r_ram_rst_n;
    assign o_ram_cs_n    = r_ram_cs_n;
    assign o_ram_wr_n    = r_ram_wr_n;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_data_in = r_ram_data_in;
endmodule

// File: tb/tb_dw_ram_rw_arb.sv
// tb_dw_ram_rw_arb: directed-vector bench for dw_ram_rw_arb with a small flop RAM model.
module tb_dw_ram_rw_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata;
    logic       ram_rst_n, ram_cs_n, ram_wr_n;
    logic [2:0] ram_addr;
    logic [7:0] ram_data_in, ram_data_out;
    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] mem [8];
    logic       prev_wr_n = 1'b1;

    always #5 clk = ~clk;

    dw_ram_rw_arb #(.data_width(8), .depth(8), .addr_width(3)) dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
        .o_rdata(rdata), .o_ram_rst_n(ram_rst_n), .o_ram_cs_n(ram_cs_n),
        .o_ram_wr_n(ram_wr_n), .o_ram_addr(ram_addr), .o_ram_data_in(ram_data_in),
        .i_ram_data_out(ram_data_out)
    );

    // RAM: asynchronous read, commit on a wr_n rise while selected, cleared while rst_n is low.
    assign ram_data_out = mem[ram_addr];
    always @(posedge clk) begin
        prev_wr_n <= ram_wr_n;
        if (!ram_rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
        end else if (!prev_wr_n && ram_wr_n && !ram_cs_n) begin
            mem[ram_addr] <= ram_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wr(input bit k, input logic [2:0] a, input logic [7:0] d);
        tick;
        if (k) begin req1 = 1; we1 = 1; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = 1; addr0 = a; wdata0 = d; end
        #1 chk("wr_gnt", k ? gnt1 : gnt0, 1);
        tick;
        if (k) req1 = 0; else req0 = 0;
        tick;
        tick;
        #1 chk("wr_done", k ? done1 : done0, 1);
    endtask

    task automatic rd(input bit k, input logic [2:0] a, input logic [7:0] d);
        tick;
        if (k) begin req1 = 1; we1 = 0; addr1 = a; end
        else   begin req0 = 1; we0 = 0; addr0 = a; end
        #1 chk("rd_gnt", k ? gnt1 : gnt0, 1);
        tick;
        if (k) req1 = 0; else req0 = 0;
        tick;
        #1 chk("rd_done", k ? done1 : done0, 1);
        chk("rd_data", rdata, d);
    endtask

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) tick;
        #1 chk("rst_ram_rst_n", ram_rst_n, 0);
        chk("rst_cs_n", ram_cs_n, 1);
        chk("rst_wr_n", ram_wr_n, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_data_in, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        rst = 0;
        tick;
        #1 chk("post_rst_ram_rst_n0", ram_rst_n, 0);
        tick;
        #1 chk("post_rst_ram_rst_n1", ram_rst_n, 1);
        chk("idle_no_gnt", {gnt0, gnt1}, 0);

        // write 0xA5 to address 5, cycle by cycle
        tick;
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 8'hA5;
        #1 chk("w5_gnt0", gnt0, 1);
        chk("w5_gnt1", gnt1, 0);
        tick;
        req0 = 0;
        #1 chk("w5_setup_wr_n", ram_wr_n, 0);
        chk("w5_setup_cs_n", ram_cs_n, 0);
        chk("w5_setup_addr", ram_addr, 5);
        chk("w5_setup_gnt", gnt0, 0);
        tick;
        #1 chk("w5_hold_wr_n", ram_wr_n, 1);
        chk("w5_hold_cs_n", ram_cs_n, 0);
        chk("w5_hold_addr", ram_addr, 5);
        chk("w5_hold_din", ram_data_in, 8'hA5);
        chk("w5_hold_done", done0, 0);
        tick;
        #1 chk("w5_done", {done0, done1}, 2'b10);
        chk("w5_idle_cs_n", ram_cs_n, 1);

        // read address 5 back
        tick;
        req0 = 1; we0 = 0; addr0 = 5;
        #1 chk("r5_gnt0", gnt0, 1);
        tick;
        req0 = 0;
        #1 chk("r5_read_cs_n", ram_cs_n, 0);
        chk("r5_read_wr_n", ram_wr_n, 1);
        chk("r5_read_done", done0, 0);
        tick;
        #1 chk("r5_done", done0, 1);
        chk("r5_rdata", rdata, 8'hA5);

        wr(1, 1, 8'h11);
        wr(1, 2, 8'h22);

        // tie with last=1: grants alternate 0,1,0,1
        tick;
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 2;
        #1 chk("tie_gnt0_first", gnt0, 1);
        chk("tie_gnt1_first", gnt1, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            #1 chk("tie_read_cs_n", ram_cs_n, 0);
            tick;
            if (i == 3) begin req0 = 0; req1 = 0; end
            #1 chk("tie_done0", done0, (i % 2 == 0) ? 1 : 0);
            chk("tie_done1", done1, (i % 2 == 1) ? 1 : 0);
            chk("tie_rdata", rdata, (i % 2 == 0) ? 8'h11 : 8'h22);
            chk("tie_gnt0", gnt0, (i < 3 && i % 2 == 1) ? 1 : 0);
            chk("tie_gnt1", gnt1, (i < 3 && i % 2 == 0) ? 1 : 0);
        end

        rd(0, 5, 8'hA5);

        // last=0: pending write from 1 beats pending read from 0 to the same word
        tick;
        req0 = 1; we0 = 0; addr0 = 7;
        req1 = 1; we1 = 1; addr1 = 7; wdata1 = 8'h3C;
        #1 chk("haz_gnt1", gnt1, 1);
        chk("haz_gnt0", gnt0, 0);
        tick;
        req1 = 0;
        #1 chk("haz_setup_wr_n", ram_wr_n, 0);
        chk("haz_no_gnt", gnt0, 0);
        tick;
        tick;
        #1 chk("haz_done1", done1, 1);
        chk("haz_gnt0_same_cycle", gnt0, 1);
        tick;
        req0 = 0;
        #1 chk("haz_read_cs_n", ram_cs_n, 0);
        tick;
        #1 chk("haz_done0", done0, 1);
        chk("haz_rdata", rdata, 8'h3C);

        wr(0, 6, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            tick;
            #1 chk("hold_cs_n", ram_cs_n, 1);
            chk("hold_wr_n", ram_wr_n, 1);
            chk("hold_addr", ram_addr, 6);
            chk("hold_din", ram_data_in, 8'h5A);
            chk("hold_rdata", rdata, 8'h3C);
        end

        // reset lands during WR_SETUP
        tick;
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 8'h77;
        #1 chk("mid_gnt0", gnt0, 1);
        tick;
        req0 = 0; rst = 1;
        #1 chk("mid_setup_wr_n", ram_wr_n, 0);
        tick;
        rst = 0;
        #1 chk("mid_ram_rst_n", ram_rst_n, 0);
        chk("mid_cs_n", ram_cs_n, 1);
        chk("mid_wr_n", ram_wr_n, 1);
        chk("mid_addr", ram_addr, 0);
        chk("mid_done", {done0, done1}, 0);
        tick;
        #1 chk("mid_post_ram_rst_n0", ram_rst_n, 0);
        chk("mid_post_done", {done0, done1}, 0);
        tick;
        #1 chk("mid_post_ram_rst_n1", ram_rst_n, 1);
        rd(1, 7, 8'h00);
        rd(0, 6, 8'h00);
        rd(0, 5, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dw_ram_rw_arb.md
# dw_ram_rw_arb

Two-requester round-robin arbiter and access sequencer for a single-port, flip-flop-based RAM with asynchronous read and wr_n-rising-edge write (cs_n, wr_n, rw_addr, data_in, data_out). The block sits between two synchronous clients and one RAM instance. It serialises their read and write commands and generates the RAM strobes from registered outputs so that address and data are stable around the wr_n edge. It returns read data and completion pulses in the clock domain. RAM test_mode/test_clk are tied off at the top level and are outside this block.

## Interface
- data_width, 8, RAM word width
- depth, 8, RAM word count (2..256)
- addr_width, 3, ceil(log2(depth))
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous and active-high
- req0 / req1  in  1  command request; held until gnt of same index
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  addr_width  word address; valid with req
- wdata0 / wdata1  in  data_width  write data; valid with req and we
- gnt0 / gnt1  out  1  combinational accept pulse; command sampled at this edge
- done0 / done1  out  1  one-cycle completion pulse (read or write)
- rdata  out  data_width  read result; valid when done of a read is high, otherwise holds
- ram_rst_n  out  1  RAM reset, active-low, registered
- ram_cs_n  out  1  RAM chip select, registered
- ram_wr_n  out  1  RAM write strobe, registered
- ram_addr  out  addr_width  RAM rw_addr, registered
- ram_data_in  out  data_width  RAM data_in, registered
- ram_data_out  in  data_width  RAM data_out, asynchronous

## Operation
- FSM states: IDLE, READ, WR_SETUP, WR_HOLD.
- IDLE: if any req, choose winner; assert gnt_k combinationally; latch we/addr/wdata of winner; next state READ (we=0) or WR_SETUP (we=1). No req: stay IDLE, no gnt.
- Arbitration: round-robin with one-bit pointer `last`. When both requests are present, the winner is the requester that is not `last`. A single request always wins. `last` updates only on a grant. After reset, `last`=1, so requester 0 wins the first tie.
- READ: ram_cs_n=0, ram_wr_n=1, ram_addr=latched. At the end of the cycle, ram_data_out is captured into rdata. Next state IDLE. done_k=1 in that IDLE cycle.
- WR_SETUP: ram_cs_n=0, ram_wr_n=0, addr and data driven.
- WR_HOLD: ram_wr_n=1, which is the RAM commit edge. ram_cs_n, ram_addr and ram_data_in are unchanged, giving hold margin. Next state IDLE, with done_k=1 in that cycle.
- IDLE outputs: ram_cs_n=1, ram_wr_n=1. ram_addr and ram_data_in hold their last values.
- Only one of gnt0/gnt1 is ever high. Only one of done0/done1 is ever high. gnt and done can be high in the same IDLE cycle: completion of the previous command and grant of the next.
- Requests arriving during non-IDLE states wait. The arbiter does not look at req outside IDLE.
- ram_rst_n: 0 while rst=1 and for the first cycle after it; 1 thereafter. This clears the RAM to zeros on every controller reset.

## Timing
- Reset values: gnt0/1=0 (no requests during reset), done0/1=0, rdata=0, ram_rst_n=0, ram_cs_n=1, ram_wr_n=1, ram_addr=0, ram_data_in=0, state IDLE, last=1.
- rst dominates every state. A reset asserted during WR_SETUP returns to IDLE. The resulting wr_n rise may corrupt one word, and ram_rst_n=0 then clears the whole RAM, so no write is guaranteed.
- Read: gnt at cycle N, READ at N+1, done and rdata valid at N+2. Occupancy is 2 cycles, so back-to-back reads reach 1 per 2 cycles.
- Write: gnt at N, WR_SETUP at N+1, WR_HOLD at N+2, done at N+3. Occupancy is 3 cycles.
- A read immediately after a write to the same address returns the new data. The write is committed at the start of WR_HOLD, before the read's READ cycle.
- Address wrap: there is none. Addresses ≥ depth are passed through unchanged; behaviour is RAM-defined and is not checked.

## Test plan
- Reset release: rst high 3 cycles, then low → ram_rst_n=0 through the first post-reset cycle, then 1. All other outputs at their reset values. No gnt without req.
- Single write then read: req0 we0=1 addr0=5 wdata0=0xA5 → gnt0 at N, ram_wr_n=0 at N+1, ram_wr_n=1 with ram_addr=5 and ram_data_in=0xA5 at N+2, done0 at N+3. Then read addr 5 → done0 with rdata=0xA5 two cycles after gnt0.
- Round-robin tie: req0 and req1 held high with reads to addr 1 and 2 → grant order 0,1,0,1. Each gnt is followed by the matching done 2 cycles later. rdata matches the previously written contents.
- Write/read hazard: req1 write addr 7=0x3C while req0 read addr 7 is also pending, with last=0 → requester 1 is granted first. The read then returns 0x3C.
- Reset mid-write: assert rst during WR_SETUP → state IDLE and ram_rst_n=0 on the next cycle. No done pulse. A subsequent read of any address returns 0x00.
- Idle hold: no req for 10 cycles after a write → ram_cs_n=1 and ram_wr_n=1 constant, ram_addr/ram_data_in unchanged, rdata unchanged.
